// File: rtl/tap_period_meter.sv
// -----------------------------------------------------------------------------
// tap_period_meter
//
// Measures the interval between successive rising edges of the debounced tap
// input. The interval is counted in timepulse ticks (tp_i), not in raw clock
// cycles. Each accepted measurement is presented on a valid/ready output.
//
// Optional feature macro: TAP_AVERAGE_EN
//   When defined, period_o carries the truncated mean of the last four
//   accepted measurements, and the output arrives one cycle later. When
//   undefined (the default), period_o carries the raw latest measurement.
//
// Parameters:
//   PERIOD_WIDTH  width of the tick counter and of period_o
//   TIMEOUT       tick count at which a measurement is abandoned
//                 (must be <= 2^PERIOD_WIDTH-1 and > MIN_PERIOD)
//   MIN_PERIOD    taps arriving before this many ticks are treated as glitches
//
// Ports:
//   clk_i      in   clock
//   rst_i      in   asynchronous active-high reset
//   tp_i       in   timepulse, one clk_i cycle wide
//   tap_i      in   debounced tap level; its rising edge marks a tap
//   ready_i    in   downstream accepts period_o
//   period_o   out  measured period in ticks
//   valid_o    out  period_o holds an unconsumed measurement
//   timeout_o  out  one-cycle pulse when a measurement is abandoned
//   overrun_o  out  one-cycle pulse when an unconsumed value is overwritten
// -----------------------------------------------------------------------------
module tap_period_meter #(
    parameter int PERIOD_WIDTH = 16,
    parameter int TIMEOUT      = 65535,
    parameter int MIN_PERIOD   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    tp_i,
    input  logic                    tap_i,
    input  logic                    ready_i,
    output logic [PERIOD_WIDTH-1:0] period_o,
    output logic                    valid_o,
    output logic                    timeout_o,
    output logic                    overrun_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    localparam logic [PERIOD_WIDTH-1:0] C_MIN_PERIOD = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] C_TO_LAST    = PERIOD_WIDTH'(TIMEOUT - 1);

    state_t                  r_state;
    logic [PERIOD_WIDTH-1:0] r_cnt;
    logic                    r_tap_q;
    logic                    r_timeout;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic                    r_valid;
    logic                    r_overrun;

    logic                    w_tap_edge;
    logic [PERIOD_WIDTH-1:0] w_cnt_next;
    logic                    w_meas;
    logic                    w_timeout;
    logic                    w_load;
    logic [PERIOD_WIDTH-1:0] w_load_val;

    // tap_q resets to 0, so a tap held high through reset release is an edge.
    assign w_tap_edge = tap_i & ~r_tap_q;

    // A tick coincident with the tap belongs to the interval being closed.
    assign w_cnt_next = r_cnt + {{(PERIOD_WIDTH-1){1'b0}}, tp_i};

    assign w_meas = (r_state == ST_COUNT) && w_tap_edge && (w_cnt_next >= C_MIN_PERIOD);

    // A tap in the same cycle as the final tick wins over the timeout.
    assign w_timeout = (r_state == ST_COUNT) && tp_i && (r_cnt == C_TO_LAST) && !w_meas;

    // -------------------------------------------------------------------------
    // Measurement FSM: interval counter, edge register and timeout pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_tap_q   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_tap_q   <= tap_i;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    // The tick in the arming cycle is not part of the interval.
                    if (w_tap_edge) begin
                        r_state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (w_meas) begin
                        // The accepted tap also opens the next interval.
                        r_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        // Glitch taps fall through here and keep counting.
                        r_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef TAP_AVERAGE_EN
    // -------------------------------------------------------------------------
    // Averaging stage: four-deep history of accepted measurements. The history
    // is registered on the measurement cycle and summed on the next, so the
    // output side sees the average one cycle after the raw measurement.
    // -------------------------------------------------------------------------
    logic [PERIOD_WIDTH-1:0] r_hist [4];
    logic                    r_hist_vld;
    logic                    r_avg_go;
    logic [PERIOD_WIDTH+1:0] w_slot_ext [4];
    logic [PERIOD_WIDTH+1:0] w_sum;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                r_hist[i] <= '0;
            end
            r_hist_vld <= 1'b0;
            r_avg_go   <= 1'b0;
        end else begin
            r_avg_go <= w_meas;
            if (w_meas) begin
                r_hist_vld <= 1'b1;
                r_hist[0]  <= w_cnt_next;
                // An empty history is filled entirely by the first value so
                // the first average equals that measurement.
                for (int i = 1; i < 4; i++) begin
                    r_hist[i] <= r_hist_vld ? r_hist[i-1] : w_cnt_next;
                end
            end else if (w_timeout) begin
                r_hist_vld <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_slot_ext
        assign w_slot_ext[gi] = {2'b00, r_hist[gi]};
    end

    assign w_sum      = w_slot_ext[0] + w_slot_ext[1] + w_slot_ext[2] + w_slot_ext[3];
    assign w_load     = r_avg_go;
    assign w_load_val = PERIOD_WIDTH'(w_sum >> 2);
`else
    assign w_load     = w_meas;
    assign w_load_val = w_cnt_next;
`endif

    // -------------------------------------------------------------------------
    // Output register and valid/ready handshake
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_load) begin
                // With ready_i high the old value is consumed this cycle,
                // so only an unaccepted value counts as overwritten.
                r_period  <= w_load_val;
                r_valid   <= 1'b1;
                r_overrun <= r_valid & ~ready_i;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign period_o  = r_period;
    assign valid_o   = r_valid;
    assign timeout_o = r_timeout;
    assign overrun_o = r_overrun;

endmodule

// File: tb/tb_tap_period_meter.sv
// -----------------------------------------------------------------------------
// tb_tap_period_meter
//
// Drives tap_period_meter with directed scenarios and randomized tap gaps.
// The reference model works on timestamps: it keeps a running count of all
// timepulse ticks and measures each interval as the tick count at the closing
// tap minus the tick count at the opening tap. Outputs are compared every
// cycle, plus explicit expected values for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_tap_period_meter;

    localparam int PW      = 16;
    localparam int TMO     = 1000;
    localparam int MIN_PER = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          tp_i;
    logic          tap_i;
    logic          ready_i;
    logic [PW-1:0] period_o;
    logic          valid_o;
    logic          timeout_o;
    logic          overrun_o;

    always #5 clk_i = ~clk_i;

    tap_period_meter #(
        .PERIOD_WIDTH (PW),
        .TIMEOUT      (TMO),
        .MIN_PERIOD   (MIN_PER)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .tp_i      (tp_i),
        .tap_i     (tap_i),
        .ready_i   (ready_i),
        .period_o  (period_o),
        .valid_o   (valid_o),
        .timeout_o (timeout_o),
        .overrun_o (overrun_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // stimulus state
    logic [1:0] phase = 2'd0;

    // reference model state
    int gticks  = 0;   // total ticks issued since time zero
    bit m_prev_tap;
    bit m_armed;
    int m_start;       // gticks value when the current interval opened
    bit m_valid;
    int m_period;
    bit m_ovr;
    bit m_to;
    int m_hist[$];
    bit m_pend;
    int m_pend_val;
    int mark;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev_tap = 1'b0;
        m_armed    = 1'b0;
        m_start    = 0;
        m_valid    = 1'b0;
        m_period   = 0;
        m_ovr      = 1'b0;
        m_to       = 1'b0;
        m_hist.delete();
        m_pend     = 1'b0;
        m_pend_val = 0;
    endtask

    task automatic deliver(input bit load, input int val);
        bit had;
        had = m_valid;
        if (load) begin
            m_ovr    = had && !ready_i;
            m_period = val;
            m_valid  = 1'b1;
            $display("[%0t] measurement %0d presented, overrun=%0d", $time, val, m_ovr);
        end else if (had && ready_i) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic model_step();
        bit edge_seen;
        bit meas;
        int el;
        int val;
        int sum;
        meas  = 1'b0;
        val   = 0;
        m_ovr = 1'b0;
        m_to  = 1'b0;
        if (tp_i) gticks++;
        if (rst_i) begin
            model_reset();
            return;
        end
        edge_seen  = tap_i && !m_prev_tap;
        m_prev_tap = tap_i;
        if (m_armed) begin
            el = gticks - m_start;
            if (edge_seen && el >= MIN_PER) begin
                meas    = 1'b1;
                val     = el;
                m_start = gticks;
            end else if (tp_i && el == TMO) begin
                m_to    = 1'b1;
                m_armed = 1'b0;
                m_hist.delete();
                $display("[%0t] timeout after %0d ticks", $time, el);
            end
        end else if (edge_seen) begin
            m_armed = 1'b1;
            m_start = gticks;
        end
`ifdef TAP_AVERAGE_EN
        deliver(m_pend, m_pend_val);
        m_pend = meas;
        if (meas) begin
            if (m_hist.size() == 0) begin
                for (int i = 0; i < 4; i++) m_hist.push_back(val);
            end else begin
                m_hist.push_back(val);
                void'(m_hist.pop_front());
            end
            sum = 0;
            foreach (m_hist[i]) sum += m_hist[i];
            m_pend_val = sum / 4;
        end
`else
        sum = 0;
        deliver(meas, val + sum);
`endif
    endtask

    task automatic compare_all();
        check_eq("valid_o",   32'(valid_o),   32'(m_valid));
        check_eq("period_o",  32'(period_o),  m_period);
        check_eq("timeout_o", 32'(timeout_o), 32'(m_to));
        check_eq("overrun_o", 32'(overrun_o), 32'(m_ovr));
    endtask

    // One clock: apply inputs, advance the model, compare after the edge.
    task automatic cycle(input logic tap, input logic rdy);
        tp_i    = (phase == 2'd3);
        phase   = phase + 2'd1;
        tap_i   = tap;
        ready_i = rdy;
        model_step();
        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    task automatic run_idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, rdy);
    endtask

    task automatic run_rand(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
    endtask

    // Runs until the total tick count reaches target; always stops on a tick
    // cycle, so the following cycle carries no tick.
    task automatic wait_ticks_until(input int target, input logic rdy);
        int budget;
        budget = 20000;
        while (gticks < target && budget > 0) begin
            cycle(1'b0, rdy);
            budget--;
        end
        check_eq("tick_wait", 32'(gticks), 32'(target));
    endtask

    task automatic press(input logic rdy);
        cycle(1'b1, rdy);
        mark = gticks;
    endtask

    initial begin
        int gap;
        int hold;
        rst_i   = 1'b1;
        tp_i    = 1'b0;
        tap_i   = 1'b0;
        ready_i = 1'b0;
        model_reset();
        #1;
        check_eq("rst_valid",   32'(valid_o),   32'd0);
        check_eq("rst_period",  32'(period_o),  32'd0);
        check_eq("rst_timeout", 32'(timeout_o), 32'd0);
        check_eq("rst_overrun", 32'(overrun_o), 32'd0);
        run_idle(3, 1'b0);
        rst_i = 1'b0;
        run_idle(8, 1'b0);

        // Reset in the middle of a measurement with a value pending.
        press(1'b0);
        wait_ticks_until(mark + 40, 1'b0);
        press(1'b0);
        wait_ticks_until(mark + 20, 1'b0);
        check_eq("pre_reset_valid", 32'(valid_o), 32'd1);
        rst_i = 1'b1;
        #2;
        check_eq("async_valid",   32'(valid_o),   32'd0);
        check_eq("async_period",  32'(period_o),  32'd0);
        check_eq("async_timeout", 32'(timeout_o), 32'd0);
        check_eq("async_overrun", 32'(overrun_o), 32'd0);
        model_reset();
        cycle(1'b0, 1'b0);
        rst_i = 1'b0;
        run_idle(4, 1'b0);
        press(1'b0);
        wait_ticks_until(mark + 50, 1'b0);
        press(1'b0);
`ifndef TAP_AVERAGE_EN
        check_eq("after_reset_period", 32'(period_o), 32'd50);
        check_eq("after_reset_valid",  32'(valid_o),  32'd1);
`endif

        // Taps 100 ticks apart, held until ready.
        run_idle(20, 1'b1);
        press(1'b1);
        wait_ticks_until(mark + 100, 1'b0);
        press(1'b0);
        run_idle(3, 1'b0);
        check_eq("hold_period", 32'(period_o), 32'd100);
        check_eq("hold_valid",  32'(valid_o),  32'd1);
        cycle(1'b0, 1'b1);
        check_eq("consumed_valid", 32'(valid_o), 32'd0);

        // Timeout, then a re-arming tap, then a 30-tick measurement.
        run_idle(20, 1'b1);
        press(1'b1);
        wait_ticks_until(mark + TMO, 1'b1);
        check_eq("timeout_pulse", 32'(timeout_o), 32'd1);
        cycle(1'b0, 1'b1);
        check_eq("timeout_single", 32'(timeout_o), 32'd0);
        run_idle(6, 1'b1);
        press(1'b1);
        check_eq("rearm_no_output", 32'(valid_o), 32'd0);
        wait_ticks_until(mark + 30, 1'b1);
        press(1'b1);
`ifndef TAP_AVERAGE_EN
        check_eq("post_timeout_period", 32'(period_o), 32'd30);
`endif

        // Glitch tap 2 ticks after the opening tap is ignored.
        run_idle(20, 1'b1);
        press(1'b1);
        wait_ticks_until(mark + 2, 1'b1);
        cycle(1'b1, 1'b1);
        check_eq("glitch_no_output", 32'(valid_o), 32'd0);
        wait_ticks_until(mark + 100, 1'b1);
        press(1'b1);
`ifndef TAP_AVERAGE_EN
        check_eq("glitch_period", 32'(period_o), 32'd100);
`endif

        // Overrun: 100 then 120 with no consumer.
        run_idle(20, 1'b1);
        press(1'b0);
        wait_ticks_until(mark + 100, 1'b0);
        press(1'b0);
        wait_ticks_until(mark + 120, 1'b0);
        press(1'b0);
`ifndef TAP_AVERAGE_EN
        check_eq("ovr_period",  32'(period_o),  32'd120);
        check_eq("ovr_valid",   32'(valid_o),   32'd1);
        check_eq("ovr_pulse",   32'(overrun_o), 32'd1);
        cycle(1'b0, 1'b0);
        check_eq("ovr_single",  32'(overrun_o), 32'd0);
`endif

        // Tap on the very tick that would time out: tap wins.
        run_idle(20, 1'b1);
        press(1'b1);
        wait_ticks_until(mark + TMO - 1, 1'b1);
        run_idle(3, 1'b1);
        cycle(1'b1, 1'b0);
`ifndef TAP_AVERAGE_EN
        check_eq("tap_wins_period",  32'(period_o),  32'(TMO));
        check_eq("tap_wins_timeout", 32'(timeout_o), 32'd0);
`endif

`ifdef TAP_AVERAGE_EN
        // Running average after a timeout empties the history.
        run_idle(20, 1'b1);
        press(1'b1);
        wait_ticks_until(mark + TMO, 1'b1);
        run_idle(4, 1'b1);
        press(1'b0);
        wait_ticks_until(mark + 100, 1'b0);
        press(1'b0);
        cycle(1'b0, 1'b0);
        check_eq("avg_1", 32'(period_o), 32'd100);
        wait_ticks_until(mark + 100, 1'b0);
        press(1'b0);
        cycle(1'b0, 1'b0);
        check_eq("avg_2", 32'(period_o), 32'd100);
        wait_ticks_until(mark + 100, 1'b0);
        press(1'b0);
        cycle(1'b0, 1'b0);
        check_eq("avg_3", 32'(period_o), 32'd100);
        wait_ticks_until(mark + 120, 1'b0);
        press(1'b0);
        cycle(1'b0, 1'b0);
        check_eq("avg_4", 32'(period_o), 32'd105);
`endif

        // Randomized tap gaps, tap hold lengths and ready behaviour.
        for (int k = 0; k < 60; k++) begin
            gap  = ($urandom_range(0, 9) == 0) ? 4100 : int'($urandom_range(1, 600));
            hold = int'($urandom_range(1, 3));
            run_rand(gap);
            for (int h = 0; h < hold; h++) cycle(1'b1, 1'($urandom_range(0, 1)));
        end
        run_rand(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tap_period_meter.md
# tap_period_meter

Consumer of the one-cycle timepulse stream: counts timepulse ticks between successive rising edges of the debounced tap input and presents each measured tap period on a valid/ready output. It sits between the timepulse generator and debouncer upstream and the BPM conversion and display logic downstream. Period unit is one timepulse tick; the block never counts raw clock cycles.

## Interface
- PERIOD_WIDTH, 16: width of the tick counter and of period_o.
- TIMEOUT, 65535: tick count at which a measurement is abandoned. Must be ≤ 2^PERIOD_WIDTH−1 and > MIN_PERIOD.
- MIN_PERIOD, 16: taps arriving with counter < MIN_PERIOD are ignored as glitches.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- tp_i  in  1  timepulse, one clk_i cycle wide.
- tap_i  in  1  debounced tap level; the rising edge marks a tap.
- ready_i  in  1  downstream accepts period_o.
- period_o  out  PERIOD_WIDTH  measured period in ticks.
- valid_o  out  1  period_o holds an unconsumed measurement.
- timeout_o  out  1  one-cycle pulse when a measurement is abandoned.
- overrun_o  out  1  one-cycle pulse when an unconsumed measurement is overwritten.

## Operation
- Edge detect: tap_q registers tap_i; tap_edge = tap_i & ~tap_q. tap_q resets to 0, so tap_i high at reset release counts as an edge.
- States:
  - IDLE: counter held at 0. tap_edge → COUNT, counter = 0 (tp_i in the same cycle is not counted).
  - COUNT: tp_i → counter + 1.
- COUNT, tap_edge with cnt_next ≥ MIN_PERIOD:
  - Load period_o = cnt_next, where cnt_next = counter + tp_i (a tick coincident with the tap is included).
  - Set valid_o; restart counter at 0. The tap also starts the next interval.
  - Stay in COUNT.
- COUNT, tap_edge with cnt_next < MIN_PERIOD: tap ignored; counter continues (tp_i still counted).
- Timeout: in COUNT, tp_i with counter == TIMEOUT−1 → state IDLE, counter 0, timeout_o = 1 for one cycle. valid_o and period_o are unaffected. If tap_edge occurs in that same cycle, the tap wins: a measurement of TIMEOUT is produced and there is no timeout.
- Handshake:
  - valid_o stays high with period_o stable until a cycle with valid_o & ready_i, then clears.
  - New measurement while valid_o & ~ready_i: period_o is overwritten, valid_o stays 1, overrun_o pulses.
  - New measurement while valid_o & ready_i: old value is consumed, the new value loads, valid_o stays 1, no overrun.
- Counter width is PERIOD_WIDTH; it cannot wrap because the timeout fires first.

## Timing
- Reset values: period_o 0, valid_o 0, timeout_o 0, overrun_o 0, state IDLE, counter 0, tap_q 0.
- Latency: tap_i sampled high at posedge N (with tap_q 0) → period_o/valid_o updated at posedge N (visible in cycle N+1). With TAP_AVERAGE_EN, one extra cycle.
- timeout_o and overrun_o are registered and exactly one cycle wide.
- rst_i mid-measurement aborts everything immediately; no output is produced for the interrupted interval.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- TAP_AVERAGE_EN defined:
  - period_o = (sum of last 4 accepted measurements) >> 2; sum width PERIOD_WIDTH+2, truncating.
  - History resets to empty on rst_i and on timeout.
  - The first measurement after empty history fills all 4 slots.
  - Averaging uses one pipeline stage, so valid_o/overrun_o assert one cycle later than the raw measurement.
- TAP_AVERAGE_EN undefined: period_o is the raw latest measurement; no history registers.

## Test plan
Setup: PERIOD_WIDTH=16, TIMEOUT=1000, MIN_PERIOD=4, tp_i every 4 clocks.
- Reset: assert rst_i mid-COUNT → all outputs 0 asynchronously; a tap then a second tap 50 ticks later after release → period_o=50, valid_o=1.
- Taps 100 ticks apart, ready_i=0 → period_o=100, valid_o held; ready_i=1 one cycle → valid_o=0 next cycle.
- Tap, then no tap for 1000 ticks → timeout_o single pulse, state IDLE; next tap produces no output; a tap 30 ticks after that → period_o=30.
- Tap, glitch tap 2 ticks later, tap at 100 ticks → one measurement only, period_o=100.
- Measurements 100 then 120, ready_i=0 throughout → period_o=120, valid_o=1, overrun_o one pulse.
- TAP_AVERAGE_EN: periods 100, 100, 100, 120 → period_o sequence 100, 100, 100, 105.
